// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM state, RGB565 pixel type and frame word-count helper for cam_frame_writer
// Build option CAM_DOWNSCALE_2X_EN halves the window in both axes.
package cam_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  typedef logic [15:0] rgb565_t;
  function automatic int frame_words(int w, int h);
`ifdef CAM_DOWNSCALE_2X_EN
    return (w / 2) * (h / 2);
`else
    return w * h;
`endif
  endfunction
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registered rise/fall detector for a sensor sync signal
// Ports: csi_pclk/reset_n clock and async active-low reset; sig_i sampled signal;
//        rise_o/fall_o high in the cycle sig_i differs from its 1-cycle registered copy.
module cam_sync_edge (
  input  logic csi_pclk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);
  logic sig_q;
  always_ff @(posedge csi_pclk or negedge reset_n)
    if (!reset_n) sig_q <= 1'b0;
    else sig_q <= sig_i;
  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;
endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: crops a window from each sensor frame and writes it into a ping-pong buffer
// Ports: csi_pclk/reset_n clock and async active-low reset; pix_data/pix_valid/line_valid/frame_sync
//        sensor pixel stream; fb_we/fb_waddr/fb_wdata/fb_bank buffer write port; rd_bank last
//        complete bank; frame_done/frame_err one-cycle publish/discard pulses.
// Build option CAM_DOWNSCALE_2X_EN writes only even window columns and rows.
module cam_frame_writer import cam_pkg::*; #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int WIN_X0 = 160,
  parameter int WIN_Y0 = 120,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              csi_pclk,
  input  logic              reset_n,
  input  rgb565_t           pix_data,
  input  logic              pix_valid,
  input  logic              line_valid,
  input  logic              frame_sync,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output rgb565_t           fb_wdata,
  output logic              fb_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int FW = frame_words(WIN_W, WIN_H);
  localparam int XW = $clog2(SRC_W) + 1;
  localparam int YW = $clog2(SRC_H) + 1;
  localparam int CW = $clog2(FW) + 1;
  localparam logic [XW-1:0] X_LO = XW'(WIN_X0), X_HI = XW'(WIN_X0 + WIN_W), X_MAX = XW'(SRC_W);
  localparam logic [YW-1:0] Y_LO = YW'(WIN_Y0), Y_HI = YW'(WIN_Y0 + WIN_H), Y_MAX = YW'(SRC_H);
  localparam logic [CW-1:0] C_FW = CW'(FW);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fs_rise, fs_fall, lv_rise_unused, lv_fall;
  logic in_win, full, we_d, done_d, err_d, fb_bank_d, rd_bank_d;
  logic [ADDR_W-1:0] waddr_d;
  rgb565_t wdata_d;
  cam_sync_edge u_fs (.csi_pclk(csi_pclk), .reset_n(reset_n), .sig_i(frame_sync), .rise_o(fs_rise), .fall_o(fs_fall));
  cam_sync_edge u_lv (.csi_pclk(csi_pclk), .reset_n(reset_n), .sig_i(line_valid), .rise_o(lv_rise_unused), .fall_o(lv_fall));
`ifdef CAM_DOWNSCALE_2X_EN
  assign in_win = x_q >= X_LO && x_q < X_HI && y_q >= Y_LO && y_q < Y_HI && x_q[0] == X_LO[0] && y_q[0] == Y_LO[0];
`else
  assign in_win = x_q >= X_LO && x_q < X_HI && y_q >= Y_LO && y_q < Y_HI;
`endif
  assign full = cnt_q == C_FW;
  always_ff @(posedge csi_pclk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // Completion outranks a coincident frame_sync rise: a full frame is never reported short.
  always_comb begin
    state_d = (state_q == IDLE && fs_rise)   ? SYNC :
              (state_q == SYNC && fs_fall)   ? ACTIVE :
              (state_q == ACTIVE && full)    ? IDLE :
              (state_q == ACTIVE && fs_rise) ? SYNC : state_q;
  end
  // A frame_sync rise drops the pixel strobed in the same cycle.
  always_comb begin
    we_d      = state_q == ACTIVE && pix_valid && line_valid && in_win && !full && !fs_rise;
    done_d    = state_q == ACTIVE && full;
    err_d     = state_q == ACTIVE && !full && fs_rise;
    waddr_d   = we_d ? ADDR_W'(cnt_q) : fb_waddr;
    wdata_d   = we_d ? pix_data : fb_wdata;
    fb_bank_d = done_d ? ~fb_bank : fb_bank;
    rd_bank_d = done_d ? fb_bank : rd_bank;
  end
  always_comb begin
    x_d   = state_q == SYNC ? '0 : lv_fall ? '0 : (pix_valid && line_valid && x_q != X_MAX) ? x_q + XW'(1) : x_q;
    y_d   = state_q == SYNC ? '0 : (lv_fall && y_q != Y_MAX) ? y_q + YW'(1) : y_q;
    cnt_d = state_q == SYNC ? '0 : we_d ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge csi_pclk or negedge reset_n)
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      fb_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      fb_we      <= we_d;
      fb_waddr   <= waddr_d;
      fb_wdata   <= wdata_d;
      fb_bank    <= fb_bank_d;
      rd_bank    <= rd_bank_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: randomized frame stimulus checked against a window/bank reference model
module tb_cam_frame_writer;
  localparam int SRC_W = 8, SRC_H = 6, WIN_X0 = 2, WIN_Y0 = 1, WIN_W = 4, WIN_H = 3, ADDR_W = 4;
`ifdef CAM_DOWNSCALE_2X_EN
  localparam int FW = (WIN_W / 2) * (WIN_H / 2);
`else
  localparam int FW = WIN_W * WIN_H;
`endif
  logic csi_pclk = 0, reset_n = 0, pix_valid = 0, line_valid = 0, frame_sync = 0;
  logic [15:0] pix_data = 0;
  logic fb_we, fb_bank, rd_bank, frame_done, frame_err;
  logic [ADDR_W-1:0] fb_waddr;
  logic [15:0] fb_wdata;
  int checks = 0, failures = 0;
  int got_addr[$], got_data[$], got_bank[$], exp_addr[$], exp_data[$], exp_bank[$];
  int done_cnt, err_cnt, exp_done, exp_err, fb_m, rd_m;

  cam_frame_writer #(.SRC_W(SRC_W), .SRC_H(SRC_H), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W)) dut (
    .csi_pclk(csi_pclk), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .line_valid(line_valid), .frame_sync(frame_sync), .fb_we(fb_we), .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata), .fb_bank(fb_bank), .rd_bank(rd_bank), .frame_done(frame_done),
    .frame_err(frame_err));

  always #5 csi_pclk = ~csi_pclk;

  always @(negedge csi_pclk) begin
    if (fb_we) begin
      got_addr.push_back(int'(fb_waddr));
      got_data.push_back(int'(fb_wdata));
      got_bank.push_back(int'(fb_bank));
    end
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic tick();
    @(posedge csi_pclk);
    #1;
  endtask

  function automatic bit win(int x, int y);
    bit w;
    w = x >= WIN_X0 && x < WIN_X0 + WIN_W && y >= WIN_Y0 && y < WIN_Y0 + WIN_H;
`ifdef CAM_DOWNSCALE_2X_EN
    w = w && ((x - WIN_X0) % 2 == 0) && ((y - WIN_Y0) % 2 == 0);
`endif
    return w;
  endfunction

  // Sends one frame starting from frame_sync high and ending with it high again.
  // The model predicts every write from the window rules; rst_line>=0 resets mid-line.
  task automatic send_frame(input int nlines, input int last_len, input bit collide, input int rst_line);
    int n, len, base;
    bit cap, coll;
    n = 0; cap = 1; base = $urandom_range(0, 255);
    got_addr.delete(); got_data.delete(); got_bank.delete();
    exp_addr.delete(); exp_data.delete(); exp_bank.delete();
    done_cnt = 0; err_cnt = 0; exp_done = 0; exp_err = 0;
    frame_sync = 0;
    repeat (3) tick();
    for (int y = 0; y < nlines; y++) begin
      len = (y == nlines - 1 && last_len >= 0) ? last_len : SRC_W + $urandom_range(0, 2);
      line_valid = 1;
      tick();
      for (int x = 0; x < len; x++) begin
        if (y == rst_line && x == 3) begin
          tick();
          reset_n = 0;
          repeat (2) tick();
          checks += 4;
          if (fb_we !== 1'b0 || fb_waddr !== '0 || fb_wdata !== '0)
            begin failures++; $display("FAIL rst_mid_wr we=%b addr=%0d data=%0d required 0/0/0", fb_we, fb_waddr, fb_wdata); end
          if (fb_bank !== 1'b0 || rd_bank !== 1'b1)
            begin failures++; $display("FAIL rst_mid_bank fb_bank=%b rd_bank=%b required 0/1", fb_bank, rd_bank); end
          if (frame_done !== 1'b0 || frame_err !== 1'b0)
            begin failures++; $display("FAIL rst_mid_pulse done=%b err=%b required 0/0", frame_done, frame_err); end
          if (got_addr.size() !== exp_addr.size())
            begin failures++; $display("FAIL rst_mid_prewrites got=%0d required %0d", got_addr.size(), exp_addr.size()); end
          reset_n = 1; cap = 0; fb_m = 0; rd_m = 1;
        end
        repeat ($urandom_range(0, 2)) tick();
        pix_data = 16'(base * 256 + y * SRC_W + x);
        pix_valid = 1;
        coll = collide && y == nlines - 1 && x == len - 1;
        if (coll) frame_sync = 1;
        if (cap && !coll && win(x, y) && n < FW) begin
          exp_addr.push_back(n); exp_data.push_back(int'(pix_data)); exp_bank.push_back(fb_m);
          n++;
        end
        tick();
        pix_valid = 0;
      end
      line_valid = 0;
      repeat (2) tick();
    end
    frame_sync = 1;
    repeat (4) tick();
    if (cap) begin
      if (n == FW) begin exp_done = 1; rd_m = fb_m; fb_m ^= 1; end
      else exp_err = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 0; frame_sync = 1;
    repeat (3) tick();
    checks += 7;
    if (fb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b required 0", fb_we); end
    if (fb_waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%0d required 0", fb_waddr); end
    if (fb_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%0d required 0", fb_wdata); end
    if (fb_bank !== 1'b0) begin failures++; $display("FAIL reset_fb_bank got=%b required 0", fb_bank); end
    if (rd_bank !== 1'b1) begin failures++; $display("FAIL reset_rd_bank got=%b required 1", rd_bank); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b required 0", frame_done); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required 0", frame_err); end
    reset_n = 1; fb_m = 0; rd_m = 1;
    repeat (2) tick();
  endtask

  // Each scenario is a list of frames; every frame is checked write by write.
  task automatic run_frames(input string name, input int nl[], input int ll[], input bit co[], input int rl[]);
    for (int f = 0; f < nl.size(); f++) begin
      send_frame(nl[f], ll[f], co[f], rl[f]);
      checks++;
      if (got_addr.size() !== exp_addr.size())
        begin failures++; $display("FAIL %s_f%0d_count got=%0d required %0d", name, f, got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_bank[i] !== exp_bank[i])
          begin failures++; $display("FAIL %s_f%0d_wr%0d got addr=%0d data=%0d bank=%0d required addr=%0d data=%0d bank=%0d",
            name, f, i, got_addr[i], got_data[i], got_bank[i], exp_addr[i], exp_data[i], exp_bank[i]); end
      end
      checks += 3;
      if (done_cnt !== exp_done) begin failures++; $display("FAIL %s_f%0d_done got=%0d required %0d", name, f, done_cnt, exp_done); end
      if (err_cnt !== exp_err) begin failures++; $display("FAIL %s_f%0d_err got=%0d required %0d", name, f, err_cnt, exp_err); end
      if (int'(fb_bank) !== fb_m || int'(rd_bank) !== rd_m)
        begin failures++; $display("FAIL %s_f%0d_banks got fb=%b rd=%b required fb=%0d rd=%0d", name, f, fb_bank, rd_bank, fb_m, rd_m); end
    end
  endtask

  task automatic test_full_frame();
    run_frames("full", '{SRC_H}, '{-1}, '{1'b0}, '{-1});
  endtask

  task automatic test_back_to_back();
    run_frames("two", '{SRC_H, SRC_H}, '{-1, -1}, '{1'b0, 1'b0}, '{-1, -1});
  endtask

  task automatic test_short_frame();
    run_frames("short", '{4, SRC_H}, '{3, -1}, '{1'b0, 1'b0}, '{-1, -1});
  endtask

  task automatic test_collision();
    run_frames("collide", '{4, SRC_H}, '{6, -1}, '{1'b1, 1'b0}, '{-1, -1});
  endtask

  task automatic test_reset_mid_frame();
    run_frames("rstmid", '{SRC_H, SRC_H}, '{-1, -1}, '{1'b0, 1'b0}, '{2, -1});
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_short_frame();
    test_collision();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
